// File: rtl/stage_4_mem.sv
// MIPS memory-access stage: byte/half/word loads and stores over a req/ack data bus.
// Define MEM_ALIGN_EXC_EN to turn misaligned half/word accesses into addr_err without a bus request.
module stage_4_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [5:0]  op,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           sz_q, sz_d;
  logic                 sgn_q, sgn_d;
  logic [1:0]           off_q, off_d;
  logic [31:0]          load_data_q, load_data_d;
  logic                 addr_err_q, addr_err_d;
  logic                 bus_err_q, bus_err_d;

  logic                 access_c;
  logic [1:0]           sz_c;
  logic                 sgn_c;
  logic [3:0]           be_c;
  logic [31:0]          wdata_c;
  logic                 misalign_c;
  logic [7:0]           byte_c;
  logic [15:0]          half_c;
  logic [31:0]          fmt_c;

  assign access_c = mem_read | mem_write;
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);

  // Opcode decode: access size and load extension; unknown opcodes act as words.
  always_comb begin
    sz_c  = SZ_WORD;
    sgn_c = 1'b0;
    case (op)
      6'h20:   begin sz_c = SZ_BYTE; sgn_c = 1'b1; end
      6'h24:   sz_c = SZ_BYTE;
      6'h21:   begin sz_c = SZ_HALF; sgn_c = 1'b1; end
      6'h25:   sz_c = SZ_HALF;
      6'h28:   sz_c = SZ_BYTE;
      6'h29:   sz_c = SZ_HALF;
      default: sz_c = SZ_WORD;
    endcase
  end

  // Lane enables and replicated store data for the addressed size.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (sz_c)
      SZ_BYTE: begin
        be_c    = 4'b0001 << alu_result[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be_c    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  assign misalign_c = ((sz_c == SZ_HALF) && alu_result[0]) ||
                      ((sz_c == SZ_WORD) && (alu_result[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Load formatting from the latched lane offset, size and extension.
  always_comb begin
    byte_c = dbus_rdata[{off_q, 3'b000} +: 8];
    half_c = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (sz_q)
      SZ_BYTE: fmt_c = {{24{sgn_q & byte_c[7]}}, byte_c};
      SZ_HALF: fmt_c = {{16{sgn_q & half_c[15]}}, half_c};
      default: fmt_c = dbus_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    sz_d        = sz_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    addr_err_d  = addr_err_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (access_c) begin
          if (misalign_c) begin
            addr_err_d  = 1'b1;
            load_data_d = 32'h0;
            state_d     = S_DONE;
          end else begin
            addr_d  = {alu_result[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
            we_d    = mem_write;
            sz_d    = sz_c;
            sgn_d   = sgn_c;
            off_d   = alu_result[1:0];
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (dbus_ack) begin
          load_data_d = we_q ? 32'h0 : fmt_c;
          req_d       = 1'b0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
            req_d       = 1'b0;
            bus_err_d   = 1'b1;
            load_data_d = 32'h0;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      sz_q        <= SZ_BYTE;
      sgn_q       <= 1'b0;
      off_q       <= 2'b00;
      load_data_q <= 32'h0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      sz_q        <= sz_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Stall is released during reset so an abandoned access never holds the pipeline.
  assign stall = rst_n & ((state_q == S_BUSY) | ((state_q == S_IDLE) & access_c));

  assign load_data  = load_data_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;
  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;

endmodule
